// File: rtl/mem_stage.sv
// mem_stage: RISC-V memory-access stage. ALU results pass through in one cycle; loads/stores are
// serialised as little-endian bytes over an 8-bit req/ack port. Optional MEM_FWD_EN adds fwd_* outputs.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ex_we,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_wdata,
  input  logic        ma_we,
  input  logic        ma_re,
  input  logic [2:0]  ma_width,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdata,
  output logic        mem_req,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  input  logic        mem_ack,
  output logic        stall_req,
`ifdef MEM_FWD_EN
  output logic        fwd_we,
  output logic [4:0]  fwd_waddr,
  output logic [31:0] fwd_wdata,
`endif
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic [1:0]  n;
  logic [31:0] addr_l;
  logic [31:0] wdata_l;
  logic [31:0] lbuf;
  logic [31:0] lbuf_next;
  logic [2:0]  width_l;
  logic        rw_l;
  logic [4:0]  waddr_l;
  logic        req;
  logic        acc;
  logic        last_ack;

  function automatic logic [1:0] last_byte(input logic [2:0] w);
    case (w[1:0])
      2'b00:   last_byte = 2'd0;
      2'b01:   last_byte = 2'd1;
      default: last_byte = 2'd3;
    endcase
  endfunction

  // width[2] selects zero extension; word-sized transfers are returned unchanged
  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] w);
    logic signed [31:0] s;
    case (w[1:0])
      2'b00:   s = {{24{raw[7] & ~w[2]}}, raw[7:0]};
      2'b01:   s = {{16{raw[15] & ~w[2]}}, raw[15:0]};
      default: s = raw;
    endcase
    extend_load = s;
  endfunction

  assign req       = ma_we | ma_re;
  assign acc       = (state == ACCESS);
  assign stall_req = ((state == IDLE) & req) | acc;
  assign mem_req   = acc & rdy;
  assign mem_rw    = acc & rw_l;
  assign mem_addr  = acc ? (addr_l + {30'd0, n}) : 32'd0;
  assign mem_dout  = acc ? wdata_l[{n, 3'b000} +: 8] : 8'd0;
  assign last_ack  = acc & rdy & mem_ack & (n == last_byte(width_l));

  always_comb begin
    lbuf_next = lbuf;
    lbuf_next[{n, 3'b000} +: 8] = mem_din;
  end

  // request capture and load-byte assembly
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (state == IDLE && req) begin
        addr_l  <= ma_addr;
        width_l <= ma_width;
        wdata_l <= ma_wdata;
        rw_l    <= ma_we;
        waddr_l <= ex_waddr;
      end
      if (acc && mem_ack) lbuf <= lbuf_next;
    end
  end

  // control FSM and writeback registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n        <= 2'd0;
      wb_we    <= 1'b0;
      wb_waddr <= 5'd0;
      wb_wdata <= 32'd0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (req) begin
            n     <= 2'd0;
            wb_we <= 1'b0;
            state <= ACCESS;
          end else begin
            wb_we    <= ex_we;
            wb_waddr <= ex_waddr;
            wb_wdata <= ex_wdata;
          end
        end
        ACCESS: begin
          if (last_ack) begin
            n        <= 2'd0;
            state    <= DONE;
            wb_we    <= ~rw_l;
            wb_waddr <= waddr_l;
            if (!rw_l) wb_wdata <= extend_load(lbuf_next, width_l);
          end else if (mem_ack) begin
            n <= n + 2'd1;
          end
        end
        DONE: begin
          wb_we <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_FWD_EN
  always_comb begin
    fwd_we    = 1'b0;
    fwd_waddr = 5'd0;
    fwd_wdata = 32'd0;
    if (state == IDLE && !req) begin
      fwd_we    = ex_we;
      fwd_waddr = ex_waddr;
      fwd_wdata = ex_wdata;
    end else if (state == DONE) begin
      fwd_we    = wb_we;
      fwd_waddr = wb_waddr;
      fwd_wdata = wb_wdata;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage with a byte-addressed memory model and responder.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        ex_we = 1'b0;
  logic [4:0]  ex_waddr = '0;
  logic [31:0] ex_wdata = '0;
  logic        ma_we = 1'b0;
  logic        ma_re = 1'b0;
  logic [2:0]  ma_width = '0;
  logic [31:0] ma_addr = '0;
  logic [31:0] ma_wdata = '0;
  logic        mem_req;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din = '0;
  logic        mem_ack = 1'b0;
  logic        stall_req;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] mem [logic [31:0]];

  mem_stage dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .ma_we(ma_we), .ma_re(ma_re), .ma_width(ma_width), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack), .stall_req(stall_req),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] x);
    if (!mem.exists(x)) mem[x] = 8'($urandom);
    return mem[x];
  endfunction

  // called between a falling edge and the next rising edge; returns at the same phase
  task automatic pass(input logic we, input logic [4:0] ra, input logic [31:0] d);
    ex_we = we; ex_waddr = ra; ex_wdata = d; ma_we = 1'b0; ma_re = 1'b0;
    #1 check_val("pass_stall0", stall_req, 0);
    @(negedge clk); #1;
    check_val("pass_we", wb_we, we);
    check_val("pass_waddr", wb_waddr, ra);
    check_val("pass_wdata", wb_wdata, d);
    check_val("pass_stall1", stall_req, 0);
  endtask

  task automatic mem_op(input logic store, input logic [2:0] w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input int dly, input int drop_after);
    int nb, k, wt, drop_left, cycles, stalls;
    logic [31:0] raw, exp;
    nb = (w[1:0] == 2'b00) ? 1 : (w[1:0] == 2'b01) ? 2 : 4;
    raw = '0;
    if (!store) for (int i = 0; i < nb; i++) raw[8*i +: 8] = mem_byte(a + 32'(i));
    exp = raw;
    if (nb < 4 && !w[2] && raw[8*nb-1]) exp = raw | (32'hFFFF_FFFF << (8*nb));
    ma_we = store; ma_re = !store | 1'($urandom % 2);
    ma_width = w; ma_addr = a; ma_wdata = wd;
    ex_we = 1'($urandom); ex_waddr = rd; ex_wdata = $urandom;
    #1 check_val("stall_on_req", stall_req, 1);
    stalls = stall_req ? 1 : 0;
    k = 0; wt = 0; drop_left = 0; cycles = 0;
    while (k < nb && cycles < 200) begin
      @(negedge clk);
      cycles++;
      mem_ack = 1'b0; mem_din = 8'h00;
      if (drop_left > 0) begin
        rdy = 1'b0; mem_ack = 1'b1; mem_din = 8'hEE;
        drop_left--;
        #1;
        check_val("req_rdy_low", mem_req, 0);
        check_val("stall_rdy_low", stall_req, 1);
      end else begin
        rdy = 1'b1;
        #1;
        if (stall_req) stalls++;
        check_val("req", mem_req, 1);
        check_val("addr", mem_addr, a + 32'(k));
        check_val("rw", mem_rw, store);
        if (store) check_val("dout", mem_dout, wd[8*k +: 8]);
        if (wt >= dly) begin
          mem_ack = 1'b1;
          if (store) mem[a + 32'(k)] = wd[8*k +: 8];
          else mem_din = mem[a + 32'(k)];
          k++; wt = 0;
          if (k == drop_after) drop_left = 3;
        end else begin
          wt++;
        end
      end
    end
    check_val("op_complete", k, nb);
    @(negedge clk);
    mem_ack = 1'b0; mem_din = 8'h00; rdy = 1'b1;
    #1;
    check_val("done_stall", stall_req, 0);
    check_val("done_req", mem_req, 0);
    check_val("done_wb_we", wb_we, !store);
    if (!store) begin
      check_val("done_waddr", wb_waddr, rd);
      check_val("done_wdata", wb_wdata, exp);
    end
    if (dly == 0 && drop_after < 0) check_val("stall_cycles", stalls, nb + 1);
    ma_we = 1'b0; ma_re = 1'b0; ex_we = 1'b0;
    @(negedge clk); #1;
    check_val("exit_wb_we", wb_we, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_val("rst_mem_req", mem_req, 0);
    check_val("rst_mem_rw", mem_rw, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_dout", mem_dout, 0);
    check_val("rst_stall", stall_req, 0);
    check_val("rst_wb_we", wb_we, 0);
    check_val("rst_wb_waddr", wb_waddr, 0);
    check_val("rst_wb_wdata", wb_wdata, 0);
    rst = 1'b0;

    pass(1'b1, 5'd5, 32'h0000_1234);
    pass(1'b1, 5'd0, 32'hDEAD_BEEF);

    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    mem_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd3, 0, -1);
    check_val("lw_value", wb_wdata, 32'h1234_5678);

    mem[32'h20] = 8'h80;
    mem_op(1'b0, 3'b000, 32'h20, 32'h0, 5'd4, 0, -1);
    check_val("lb_value", wb_wdata, 32'hFFFF_FF80);
    mem_op(1'b0, 3'b100, 32'h20, 32'h0, 5'd4, 0, -1);
    check_val("lbu_value", wb_wdata, 32'h0000_0080);

    mem_op(1'b1, 3'b001, 32'h3FFF, 32'hAABB_CCDD, 5'd6, 2, -1);
    check_val("sh_byte0", mem[32'h3FFF], 8'hDD);
    check_val("sh_byte1", mem[32'h4000], 8'hCC);

    mem_op(1'b0, 3'b010, 32'h300, 32'h0, 5'd9, 0, 2);
    mem_op(1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0, 5'd10, 0, -1);

    // reset in the middle of a load, with stray acks afterwards
    ma_re = 1'b1; ma_we = 1'b0; ma_width = 3'b010; ma_addr = 32'h200; ex_we = 1'b0; ex_waddr = 5'd7;
    @(negedge clk); #1;
    check_val("abort_req0", mem_req, 1);
    mem_ack = 1'b1; mem_din = 8'h11;
    @(negedge clk); mem_ack = 1'b0; #1;
    check_val("abort_addr1", mem_addr, 32'h201);
    rst = 1'b1; mem_ack = 1'b1; ma_re = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    check_val("abort_req", mem_req, 0);
    check_val("abort_wb_we", wb_we, 0);
    check_val("abort_stall", stall_req, 0);
    @(negedge clk); mem_ack = 1'b0; #1;
    check_val("abort_late_ack", mem_req, 0);
    mem_op(1'b0, 3'b010, 32'h200, 32'h0, 5'd7, 0, -1);

    for (int it = 0; it < 40; it++) begin
      int kind, nb, drop;
      logic [2:0] w;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      w = 3'($urandom);
      a = ($urandom % 4 == 0) ? (32'hFFFF_FFFC + 32'($urandom % 4)) : 32'($urandom % 64);
      nb = (w[1:0] == 2'b00) ? 1 : (w[1:0] == 2'b01) ? 2 : 4;
      drop = (nb > 1 && $urandom % 4 == 0) ? $urandom_range(1, nb - 1) : -1;
      if (kind == 0) pass(1'($urandom), 5'($urandom), $urandom);
      else mem_op(kind == 2, w, a, $urandom, 5'($urandom), $urandom_range(0, 2), drop);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
